// File: rtl/crossbar_switch_alloc3.sv
// Per-output switch allocator for a 3x3 crossbar: round-robin arbitration,
// packet locking from head to tail, combinational grants and select lines.
module crossbar_switch_alloc3 #(
  parameter int unsigned p_nbits = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       domain,
  input  logic       req_val0,
  input  logic       req_val1,
  input  logic       req_val2,
  input  logic [1:0] req_dest0,
  input  logic [1:0] req_dest1,
  input  logic [1:0] req_dest2,
  input  logic       req_tail0,
  input  logic       req_tail1,
  input  logic       req_tail2,
  output logic       grant0,
  output logic       grant1,
  output logic       grant2,
  input  logic       out_rdy0,
  input  logic       out_rdy1,
  input  logic       out_rdy2,
  output logic       out_val0,
  output logic       out_val1,
  output logic       out_val2,
  output logic [1:0] sel0,
  output logic [1:0] sel1,
  output logic [1:0] sel2
);

  localparam int unsigned NP = 3;
  localparam int unsigned IW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Flit width and security label do not influence allocation.
  logic unused_sink;
  assign unused_sink = &{1'b0, domain, 32'(p_nbits)};

  logic [NP-1:0] val;
  logic [NP-1:0] tail;
  logic [NP-1:0] rdy;
  logic [IW-1:0] dest [NP];

  assign val     = {req_val2, req_val1, req_val0};
  assign tail    = {req_tail2, req_tail1, req_tail0};
  assign rdy     = {out_rdy2, out_rdy1, out_rdy0};
  assign dest[0] = req_dest0;
  assign dest[1] = req_dest1;
  assign dest[2] = req_dest2;

  state_t        state_q [NP];
  state_t        state_d [NP];
  logic [IW-1:0] own_q   [NP];
  logic [IW-1:0] own_d   [NP];
  logic [IW-1:0] ptr_q   [NP];
  logic [IW-1:0] ptr_d   [NP];

  logic [NP-1:0] gnt [NP];   // gnt[j][i]: output j grants input i
  logic [NP-1:0] oval;
  logic [IW-1:0] sel [NP];
  logic [NP-1:0] grant_v;

  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] idx;

  // Sum of an index and an offset, reduced modulo 3 (inputs never exceed 4).
  function automatic logic [IW-1:0] wrap3(input logic [2:0] s);
    return (s >= 3'd3) ? IW'(s - 3'd3) : IW'(s);
  endfunction

  // Per-output state: FSM, packet owner and round-robin pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j < NP; j++) begin
        state_q[j] <= IDLE;
        own_q[j]   <= '0;
        ptr_q[j]   <= '0;
      end
    end else begin
      for (int j = 0; j < NP; j++) begin
        state_q[j] <= state_d[j];
        own_q[j]   <= own_d[j];
        ptr_q[j]   <= ptr_d[j];
      end
    end
  end

  // Arbitration, lock tracking, next state and per-output grants.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx     = '0;
    grant_v = '0;
    for (int j = 0; j < NP; j++) begin
      state_d[j] = state_q[j];
      own_d[j]   = own_q[j];
      ptr_d[j]   = ptr_q[j];
      sel[j]     = '0;
      oval[j]    = 1'b0;
      gnt[j]     = '0;
    end

    for (int j = 0; j < NP; j++) begin
      // Scan from lowest priority upward so the highest-priority requester wins.
      found = 1'b0;
      win   = '0;
      for (int k = NP - 1; k >= 0; k--) begin
        idx = wrap3(3'(ptr_q[j]) + 3'(k));
        if (val[idx] && (dest[idx] == IW'(j))) begin
          found = 1'b1;
          win   = idx;
        end
      end

      case (state_q[j])
        IDLE: begin
          if (found) begin
            sel[j]      = win;
            oval[j]     = 1'b1;
            gnt[j][win] = rdy[j];
            if (rdy[j]) begin
              ptr_d[j] = wrap3(3'(win) + 3'd1);
              if (!tail[win]) begin
                state_d[j] = BUSY;
                own_d[j]   = win;
              end
            end
          end
        end
        BUSY: begin
          // A misrouted owner leaves the output stalled until reset.
          sel[j]  = own_q[j];
          oval[j] = val[own_q[j]] && (dest[own_q[j]] == IW'(j));
          if (oval[j] && rdy[j]) begin
            gnt[j][own_q[j]] = 1'b1;
            if (tail[own_q[j]]) begin
              state_d[j] = IDLE;
            end
          end
        end
        default: state_d[j] = IDLE;
      endcase
    end

    for (int j = 0; j < NP; j++) begin
      grant_v = grant_v | gnt[j];
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  assign grant0   = reset_n & grant_v[0];
  assign grant1   = reset_n & grant_v[1];
  assign grant2   = reset_n & grant_v[2];
  assign out_val0 = reset_n & oval[0];
  assign out_val1 = reset_n & oval[1];
  assign out_val2 = reset_n & oval[2];
  assign sel0     = reset_n ? sel[0] : '0;
  assign sel1     = reset_n ? sel[1] : '0;
  assign sel2     = reset_n ? sel[2] : '0;

endmodule

// File: tb/tb_crossbar_switch_alloc3.sv
// Testbench for crossbar_switch_alloc3: per-cycle vector table with a
// scoreboard of expected outputs, plus a hand-written mid-cycle reset sequence.
module tb_crossbar_switch_alloc3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       domain;
  logic       req_val0, req_val1, req_val2;
  logic [1:0] req_dest0, req_dest1, req_dest2;
  logic       req_tail0, req_tail1, req_tail2;
  logic       grant0, grant1, grant2;
  logic       out_rdy0, out_rdy1, out_rdy2;
  logic       out_val0, out_val1, out_val2;
  logic [1:0] sel0, sel1, sel2;

  always #5 clk = ~clk;

  crossbar_switch_alloc3 #(.p_nbits(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .domain    (domain),
    .req_val0  (req_val0),
    .req_val1  (req_val1),
    .req_val2  (req_val2),
    .req_dest0 (req_dest0),
    .req_dest1 (req_dest1),
    .req_dest2 (req_dest2),
    .req_tail0 (req_tail0),
    .req_tail1 (req_tail1),
    .req_tail2 (req_tail2),
    .grant0    (grant0),
    .grant1    (grant1),
    .grant2    (grant2),
    .out_rdy0  (out_rdy0),
    .out_rdy1  (out_rdy1),
    .out_rdy2  (out_rdy2),
    .out_val0  (out_val0),
    .out_val1  (out_val1),
    .out_val2  (out_val2),
    .sel0      (sel0),
    .sel1      (sel1),
    .sel2      (sel2)
  );

  // Bit i of val/tail/eg belongs to input i; bit j of rdy/eo to output j;
  // dest = {d2,d1,d0}; es = {sel2,sel1,sel0}.
  typedef struct {
    string      name;
    logic       rst;
    logic [2:0] val;
    logic [5:0] dest;
    logic [2:0] tail;
    logic [2:0] rdy;
    logic [2:0] eg;
    logic [2:0] eo;
    logic [5:0] es;
  } vec_t;

  typedef struct {
    string      name;
    logic [2:0] eg;
    logic [2:0] eo;
    logic [5:0] es;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input string name, input logic rst, input logic [2:0] val,
                              input logic [5:0] dest, input logic [2:0] tail,
                              input logic [2:0] rdy, input logic [2:0] eg,
                              input logic [2:0] eo, input logic [5:0] es);
    vec_t v;
    v.name = name; v.rst = rst; v.val = val; v.dest = dest; v.tail = tail;
    v.rdy = rdy; v.eg = eg; v.eo = eo; v.es = es;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string nm, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    exp_t e;
    reset_n   = v.rst;
    req_val0  = v.val[0];  req_val1  = v.val[1];  req_val2  = v.val[2];
    req_dest0 = v.dest[1:0]; req_dest1 = v.dest[3:2]; req_dest2 = v.dest[5:4];
    req_tail0 = v.tail[0]; req_tail1 = v.tail[1]; req_tail2 = v.tail[2];
    out_rdy0  = v.rdy[0];  out_rdy1  = v.rdy[1];  out_rdy2  = v.rdy[2];
    e.name = v.name; e.eg = v.eg; e.eo = v.eo; e.es = v.es;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: empty at %0t", $time);
    end else begin
      e = sb.pop_front();
      cmp({e.name, ".grant"},   6'({grant2, grant1, grant0}), 6'(e.eg));
      cmp({e.name, ".out_val"}, 6'({out_val2, out_val1, out_val0}), 6'(e.eo));
      cmp({e.name, ".sel"},     {sel2, sel1, sel0}, e.es);
    end
  endtask

  initial begin
    vec_t hv;

    // Reset with everyone requesting output 0, then release
    add("rst_hold0", 1'b0, 3'b111, 6'b000000, 3'b111, 3'b111, 3'b000, 3'b000, 6'b000000);
    add("rst_hold1", 1'b0, 3'b111, 6'b000000, 3'b111, 3'b111, 3'b000, 3'b000, 6'b000000);
    add("rst_rel",   1'b1, 3'b111, 6'b000000, 3'b111, 3'b111, 3'b001, 3'b001, 6'b000000);
    // Round robin on output 1 with single-flit packets
    add("rr0", 1'b1, 3'b111, 6'b010101, 3'b111, 3'b111, 3'b001, 3'b010, 6'b000000);
    add("rr1", 1'b1, 3'b111, 6'b010101, 3'b111, 3'b111, 3'b010, 3'b010, 6'b000100);
    add("rr2", 1'b1, 3'b111, 6'b010101, 3'b111, 3'b111, 3'b100, 3'b010, 6'b001000);
    add("rr3", 1'b1, 3'b111, 6'b010101, 3'b111, 3'b111, 3'b001, 3'b010, 6'b000000);
    // Packet lock on output 0: in1 three flits, in2 waits; ptr0 = 2 lets in2 beat in0
    add("lk_rst", 1'b0, 3'b000, 6'b000000, 3'b111, 3'b111, 3'b000, 3'b000, 6'b000000);
    add("lk1", 1'b1, 3'b110, 6'b000000, 3'b100, 3'b111, 3'b010, 3'b001, 6'b000001);
    add("lk2", 1'b1, 3'b110, 6'b000000, 3'b100, 3'b111, 3'b010, 3'b001, 6'b000001);
    add("lk3", 1'b1, 3'b110, 6'b000000, 3'b110, 3'b111, 3'b010, 3'b001, 6'b000001);
    add("lk4", 1'b1, 3'b101, 6'b000000, 3'b111, 3'b111, 3'b100, 3'b001, 6'b000010);
    add("lk5", 1'b1, 3'b001, 6'b000000, 3'b111, 3'b111, 3'b001, 3'b001, 6'b000000);
    // Back-pressure while in0 owns output 2 and in1 also wants it
    add("bp1", 1'b1, 3'b001, 6'b000010, 3'b110, 3'b111, 3'b001, 3'b100, 6'b000000);
    add("bp2", 1'b1, 3'b011, 6'b001010, 3'b110, 3'b011, 3'b000, 3'b100, 6'b000000);
    add("bp3", 1'b1, 3'b011, 6'b001010, 3'b110, 3'b011, 3'b000, 3'b100, 6'b000000);
    add("bp4", 1'b1, 3'b011, 6'b001010, 3'b111, 3'b111, 3'b001, 3'b100, 6'b000000);
    add("bp5", 1'b1, 3'b010, 6'b001000, 3'b111, 3'b111, 3'b010, 3'b100, 6'b010000);
    // Three non-conflicting transfers in one cycle
    add("par", 1'b1, 3'b111, 6'b010010, 3'b111, 3'b111, 3'b111, 3'b111, 6'b001001);
    // Reset while output 1 is locked to in2; afterwards in0 wins from ptr 0
    add("ar_busy", 1'b1, 3'b100, 6'b010000, 3'b011, 3'b111, 3'b100, 3'b010, 6'b001000);
    add("ar_low",  1'b0, 3'b100, 6'b010000, 3'b011, 3'b111, 3'b000, 3'b000, 6'b000000);
    add("ar_rel",  1'b1, 3'b101, 6'b010001, 3'b111, 3'b111, 3'b001, 3'b010, 6'b000000);
    // Destination 3 is never a request
    add("inv0",    1'b1, 3'b001, 6'b000011, 3'b111, 3'b111, 3'b000, 3'b000, 6'b000000);
    add("inv_all", 1'b1, 3'b111, 6'b111111, 3'b111, 3'b111, 3'b000, 3'b000, 6'b000000);
    // Owner of output 0 jumps to output 2 mid-packet: output 0 stalls, locked
    add("pv1", 1'b1, 3'b010, 6'b000000, 3'b101, 3'b111, 3'b010, 3'b001, 6'b000001);
    add("pv2", 1'b1, 3'b010, 6'b001000, 3'b111, 3'b111, 3'b010, 3'b100, 6'b010001);
    add("pv3", 1'b1, 3'b001, 6'b000000, 3'b111, 3'b111, 3'b000, 3'b000, 6'b000001);

    domain  = 1'b0;
    reset_n = 1'b0;
    {req_val0, req_val1, req_val2}    = '0;
    {req_dest0, req_dest1, req_dest2} = '0;
    {req_tail0, req_tail1, req_tail2} = '0;
    {out_rdy0, out_rdy1, out_rdy2}    = '0;

    foreach (vecs[n]) begin
      @(negedge clk);
      drive(vecs[n]);
      #1;
      check_out();
    end

    // Hand-written: lock output 1 to in2, then drop reset a few ns after the edge
    hv.name = "hs_lock"; hv.rst = 1'b1; hv.val = 3'b100; hv.dest = 6'b010000;
    hv.tail = 3'b011; hv.rdy = 3'b111; hv.eg = 3'b100; hv.eo = 3'b010; hv.es = 6'b001001;
    @(negedge clk);
    drive(hv);
    #1;
    check_out();
    @(posedge clk);
    #3;
    cmp("hs_busy.grant", 6'({grant2, grant1, grant0}), 6'b000100);
    reset_n = 1'b0;
    #1;
    cmp("hs_async.grant",   6'({grant2, grant1, grant0}), 6'b000000);
    cmp("hs_async.out_val", 6'({out_val2, out_val1, out_val0}), 6'b000000);
    cmp("hs_async.sel",     {sel2, sel1, sel0}, 6'b000000);
    hv.name = "hs_rel"; hv.rst = 1'b1; hv.val = 3'b101; hv.dest = 6'b010001;
    hv.tail = 3'b111; hv.rdy = 3'b111; hv.eg = 3'b001; hv.eo = 3'b010; hv.es = 6'b000000;
    @(negedge clk);
    drive(hv);
    #1;
    check_out();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
